// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium sequencing controller and its
// byte packer.
package trivium_pkg;

  localparam int TRIV_KEY_W      = 80;
  localparam int TRIV_IV_W       = 80;
  localparam int TRIV_WARMUP     = 1152;
  localparam int TRIV_WARM_MIN_W = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_RUN,
    S_HOLD
  } triv_state_e;

  // Warm-up counter width: clog2 of the round count, never narrower than 11.
  function automatic int warm_cnt_w(input int warmup);
    int w;
    w = $clog2(warmup);
    return (w > TRIV_WARM_MIN_W) ? w : TRIV_WARM_MIN_W;
  endfunction

endpackage

// File: rtl/trivium_byte_pack.sv
// LSB-first keystream byte packer: the first bit shifted in lands in bit 0.
// full_o flags the shift that completes a byte; byte_o is that byte.
module trivium_byte_pack (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic [7:0] byte_o,
  output logic       full_o
);

  logic [7:0] sr_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {bit_i, sr_q[7:1]};
      cnt_q <= cnt_q + 3'd1;
    end
  end

  // The eighth bit is taken straight from the input so the byte can be
  // registered downstream in the same cycle it arrives.
  assign full_o = shift_i && (cnt_q == 3'd7);
  assign byte_o = {bit_i, sr_q[7:1]};

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencing controller for the Trivium core: load, warm-up, then keystream
// bytes over valid/ready until the requested count, with abort at any point.
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int WARMUP = TRIV_WARMUP,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TRIV_KEY_W-1:0] key,
  input  logic [TRIV_IV_W-1:0]  iv,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  core_load,
  output logic [TRIV_KEY_W-1:0] core_key,
  output logic [TRIV_IV_W-1:0]  core_iv,
  output logic                  core_step,
  input  logic                  core_z
);

  localparam int WARM_W = warm_cnt_w(WARMUP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

  triv_state_e state_q, state_d;

  logic [TRIV_KEY_W-1:0] key_q;
  logic [TRIV_IV_W-1:0]  iv_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [7:0]            out_byte_q, out_byte_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;

  logic       accept;
  logic       handshake;
  logic       pack_clr;
  logic       pack_shift;
  logic       pack_full;
  logic [7:0] pack_byte;

  trivium_byte_pack u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pack_clr),
    .shift_i (pack_shift),
    .bit_i   (core_z),
    .byte_o  (pack_byte),
    .full_o  (pack_full)
  );

  assign handshake    = out_valid_q && out_ready;
  assign byte_cnt_inc = byte_cnt_q + LEN_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a
    // path through the case that skips an assignment infers a latch.
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    pack_clr    = 1'b0;
    pack_shift  = 1'b0;
    core_load   = 1'b0;
    core_step   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            accept     = 1'b1;
            pack_clr   = 1'b1;
            byte_cnt_d = '0;
            warm_cnt_d = '0;
            state_d    = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        core_load = 1'b1;
        state_d   = S_WARM;
      end
      S_WARM: begin
        core_step = 1'b1;
        if (warm_cnt_q == WARM_LAST) begin
          warm_cnt_d = '0;
          state_d    = S_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end
      S_RUN: begin
        core_step  = 1'b1;
        pack_shift = 1'b1;
        if (pack_full) begin
          out_byte_d  = pack_byte;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        // Core is stalled here, so its state survives any amount of backpressure.
        if (handshake) begin
          out_valid_d = 1'b0;
          byte_cnt_d  = byte_cnt_inc;
          if (byte_cnt_inc == len_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including the final handshake; a byte taken
    // in the abort cycle still counts, but no done is signalled.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      pack_clr    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      iv_q        <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      warm_cnt_q  <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      if (accept) begin
        key_q <= key;
        iv_q  <= iv;
        len_q <= len;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign core_key  = key_q;
  assign core_iv   = iv_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Directed bench for trivium_ctrl: a short-warm-up instance and a full-warm-up
// instance, each driving a small behavioural keystream core.
module tb_trivium_ctrl;

  localparam logic [79:0] KG = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] IG = 80'hECBB76B09AFF71D0D151;
  localparam logic [79:0] KB = 80'h0123456789ABCDEF0F1E;

  logic        clk, rst, start1, start2, abort, out_ready;
  logic [79:0] key_r, iv_r;
  logic [15:0] len_r;

  logic        busy1, done1, out_valid1, core_load1, core_step1, core_z1;
  logic [7:0]  out_byte1;
  logic [79:0] core_key1, core_iv1;
  logic        busy2, done2, out_valid2, core_load2, core_step2, core_z2;
  logic [7:0]  out_byte2;
  logic [79:0] core_key2, core_iv2;

  int checks = 0;
  int fails  = 0;
  int steps1 = 0, loads1 = 0, steps2 = 0;
  int w, sj, lj, stable, done_seen;
  logic [7:0]  b0;
  logic [15:0] sd;
  logic [15:0] m1_q = '0;
  logic [15:0] m2_q = '0;

  trivium_ctrl #(.WARMUP(4), .LEN_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .key(key_r), .iv(iv_r), .len(len_r[2:0]),
    .busy(busy1), .done(done1), .out_byte(out_byte1), .out_valid(out_valid1),
    .out_ready(out_ready), .core_load(core_load1), .core_key(core_key1),
    .core_iv(core_iv1), .core_step(core_step1), .core_z(core_z1)
  );

  trivium_ctrl dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort),
    .key(key_r), .iv(iv_r), .len(len_r),
    .busy(busy2), .done(done2), .out_byte(out_byte2), .out_valid(out_valid2),
    .out_ready(out_ready), .core_load(core_load2), .core_key(core_key2),
    .core_iv(core_iv2), .core_step(core_step2), .core_z(core_z2)
  );

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] seed_of(input logic [79:0] k, input logic [79:0] v);
    return k[15:0] ^ k[79:64] ^ v[15:0] ^ v[47:32] ^ 16'hACE1;
  endfunction

  // Byte n of the stream: warm-up steps, then 8 bits per byte, z taken before each step.
  function automatic logic [7:0] exp_byte(input logic [15:0] seed, input int warm, input int n);
    logic [15:0] s;
    logic [7:0]  b;
    s = seed;
    b = '0;
    for (int i = 0; i < warm + 8 * n; i++) s = lfsr(s);
    for (int j = 0; j < 8; j++) begin
      b[j] = s[0];
      s = lfsr(s);
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (core_load1) m1_q <= seed_of(core_key1, core_iv1);
    else if (core_step1) m1_q <= lfsr(m1_q);
    if (core_load2) m2_q <= seed_of(core_key2, core_iv2);
    else if (core_step2) m2_q <= lfsr(m2_q);
    if (core_step1) steps1 <= steps1 + 1;
    if (core_load1) loads1 <= loads1 + 1;
    if (core_step2) steps2 <= steps2 + 1;
  end

  assign core_z1 = m1_q[0];
  assign core_z2 = m2_q[0];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid1(input int lim, output int n);
    n = 0;
    while (out_valid1 !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) check("valid_timeout", out_valid1, 1'b1);
  endtask

  task automatic go1(input logic [79:0] k, input logic [79:0] v, input int n);
    key_r  = k;
    iv_r   = v;
    len_r  = 16'(n);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Collect n bytes with out_ready high, then expect done one cycle after the last.
  task automatic run_bytes1(input string tag, input logic [79:0] k, input logic [79:0] v, input int n);
    int ww;
    for (int b = 0; b < n; b++) begin
      wait_valid1(40, ww);
      check($sformatf("%s_byte%0d", tag, b), out_byte1, exp_byte(seed_of(k, v), 4, b));
      @(negedge clk);
    end
    check({tag, "_done"}, done1, 1'b1);
  endtask

  initial begin
    clk = 0; rst = 1; start1 = 0; start2 = 0; abort = 0; out_ready = 0;
    key_r = '0; iv_r = '0; len_r = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_valid", out_valid1, 1'b0);
    check("rst_byte", out_byte1, 8'h00);
    check("rst_load_step", {core_load1, core_step1}, 2'b00);
    check("rst_key_iv", core_key1 | core_iv1, 80'h0);
    rst = 0;
    @(negedge clk);

    // Basic timing: load at c+1, 12 steps, valid at c+14, done at c+15.
    out_ready = 1;
    sj = steps1;
    go1(80'h0, 80'h0, 1);
    check("t1_load", core_load1, 1'b1);
    check("t1_busy", busy1, 1'b1);
    check("t1_no_step_in_load", core_step1, 1'b0);
    wait_valid1(40, w);
    check("t1_valid_cycle", w + 1, 14);
    check("t1_byte", out_byte1, exp_byte(seed_of(80'h0, 80'h0), 4, 0));
    @(negedge clk);
    check("t1_done", done1, 1'b1);
    check("t1_busy_fall", busy1, 1'b0);
    check("t1_steps", steps1 - sj, 12);
    @(negedge clk);
    check("t1_done_pulse", done1, 1'b0);

    // Backpressure: 20 stalled cycles in HOLD, then two more bytes.
    out_ready = 0;
    sj = steps1;
    go1(KG, IG, 3);
    wait_valid1(40, w);
    check("bp_first_valid", w + 1, 14);
    b0 = out_byte1;
    check("bp_byte0", b0, exp_byte(seed_of(KG, IG), 4, 0));
    stable = 1;
    lj = steps1;
    repeat (20) begin
      @(negedge clk);
      if (out_byte1 !== b0 || out_valid1 !== 1'b1 || core_step1 !== 1'b0) stable = 0;
    end
    check("bp_stall_stable", stable, 1);
    check("bp_stall_steps", steps1 - lj, 0);
    out_ready = 1;
    @(negedge clk);
    wait_valid1(20, w);
    check("bp_gap", w + 1, 9);
    check("bp_byte1", out_byte1, exp_byte(seed_of(KG, IG), 4, 1));
    @(negedge clk);
    wait_valid1(20, w);
    check("bp_byte2", out_byte1, exp_byte(seed_of(KG, IG), 4, 2));
    @(negedge clk);
    check("bp_done", done1, 1'b1);
    check("bp_steps", steps1 - sj, 28);

    // len = 0: done next cycle, nothing else moves.
    sj = steps1;
    lj = loads1;
    go1(KB, IG, 0);
    check("z_done", done1, 1'b1);
    check("z_busy", busy1, 1'b0);
    @(negedge clk);
    check("z_done_pulse", done1, 1'b0);
    check("z_busy2", busy1, 1'b0);
    check("z_no_load_step", (loads1 - lj) + (steps1 - sj), 0);

    // Abort in WARM, then a fresh job reproduces the stream from byte 0.
    go1(KG, IG, 2);
    @(negedge clk);
    check("aw_in_warm", core_step1, 1'b1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("aw_idle", {busy1, core_step1, core_load1}, 3'b000);
    done_seen = 0;
    repeat (3) begin
      if (done1) done_seen = 1;
      @(negedge clk);
    end
    check("aw_no_done", done_seen, 0);
    go1(KG, IG, 2);
    run_bytes1("aw_restart", KG, IG, 2);

    // Abort in HOLD with out_ready low.
    out_ready = 0;
    go1(KG, IG, 2);
    wait_valid1(40, w);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("ah_idle", {busy1, out_valid1, done1}, 3'b000);
    @(negedge clk);
    check("ah_no_done", done1, 1'b0);
    out_ready = 1;
    go1(KG, IG, 1);
    run_bytes1("ah_restart", KG, IG, 1);

    // Abort coinciding with the final handshake suppresses done.
    go1(KB, IG, 1);
    wait_valid1(40, w);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("af_no_done", {done1, busy1, out_valid1}, 3'b000);

    // Largest len for a 3-bit count: 7 bytes, no wrap.
    sj = steps1;
    go1(KB, KG, 7);
    run_bytes1("max", KB, KG, 7);
    check("max_steps", steps1 - sj, 60);

    // start during a job is ignored; reset mid-RUN clears every output.
    go1(KB, IG, 2);
    @(negedge clk);
    key_r = KG;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    check("si_key_held", core_key1, KB);
    check("si_busy", busy1, 1'b1);
    wait_valid1(40, w);
    check("si_byte0", out_byte1, exp_byte(seed_of(KB, IG), 4, 0));
    @(negedge clk);
    check("rr_in_run", core_step1, 1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rr_ctrl", {busy1, done1, out_valid1, core_load1, core_step1}, 5'b0);
    check("rr_byte", out_byte1, 8'h00);
    check("rr_key_iv", core_key1 | core_iv1, 80'h0);

    // Full 1152-round warm-up, 4 bytes.
    sj = steps2;
    key_r = KG; iv_r = IG; len_r = 16'd4; out_ready = 1;
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    w = 0;
    while (out_valid2 !== 1'b1 && w < 1300) begin
      @(negedge clk);
      w++;
    end
    check("full_first_valid", w + 1, 1162);
    for (int b = 0; b < 4; b++) begin
      w = 0;
      while (out_valid2 !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("full_byte%0d", b), out_byte2, exp_byte(seed_of(KG, IG), 1152, b));
      @(negedge clk);
    end
    check("full_done", done2, 1'b1);
    check("full_steps", steps2 - sj, 1184);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
